// File: rtl/sv32_itlb_plru_pkg.sv
`default_nettype none
// ============================================================================
// sv32_itlb_plru_pkg : shared Sv32 PTE type and VPN field widths
// Revision: 1.0
// ============================================================================
package sv32_itlb_plru_pkg;

    localparam int VPN_LEVEL_W = 10;
    localparam int SV32_VPN_W  = 20;

    typedef struct packed {
        logic [21:0] ppn;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_sv32_t;

endpackage
`default_nettype wire

// File: rtl/sv32_itlb_plru_plru_tree.sv
`default_nettype none
// ============================================================================
// sv32_itlb_plru_plru_tree : tree pseudo-LRU, N-1 bits, fill marking beats hit
// Revision: 1.0
// ============================================================================
module sv32_itlb_plru_plru_tree
    import sv32_itlb_plru_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 hit_valid_i,
    input  logic [$clog2(N)-1:0] hit_idx_i,
    input  logic                 fill_valid_i,
    input  logic [$clog2(N)-1:0] fill_idx_i,
    output logic [$clog2(N)-1:0] victim_idx_o
);
    localparam int L = $clog2(N);

    // Heap-ordered nodes; a 1 means the victim lies in the right subtree.
    logic [N-2:0] tree_q, tree_d;
    logic         w_touch;
    logic [L-1:0] w_touch_idx;
    logic         w_on_path;

    always_comb begin
        w_touch     = fill_valid_i | hit_valid_i;
        w_touch_idx = fill_valid_i ? fill_idx_i : hit_idx_i;
        tree_d      = tree_q;
        if (w_touch) begin
            for (int lvl = 0; lvl < L; lvl++) begin
                for (int j = 0; j < (1 << lvl); j++) begin
                    if ((int'(w_touch_idx) >> (L - lvl)) == j) begin
                        tree_d[(1 << lvl) - 1 + j] = ~w_touch_idx[L - 1 - lvl];
                    end
                end
            end
        end
    end

    always_comb begin
        victim_idx_o = '0;
        w_on_path    = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_on_path = 1'b1;
            for (int lvl = 0; lvl < L; lvl++) begin
                if (tree_q[(1 << lvl) - 1 + (i >> (L - lvl))] != (((i >> (L - 1 - lvl)) & 1) == 1)) begin
                    w_on_path = 1'b0;
                end
            end
            if (w_on_path) begin
                victim_idx_o = L'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tree_q <= '0;
        end else begin
            tree_q <= tree_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sv32_itlb_plru.sv
`default_nettype none
// ============================================================================
// sv32_itlb_plru : fully associative Sv32 instruction TLB, tree-PLRU refill
// Revision: 1.0
// ============================================================================
module sv32_itlb_plru
    import sv32_itlb_plru_pkg::*;
#(
    parameter int TLB_ENTRIES = 2,
    parameter int ASID_WIDTH  = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  flush_asid_is0_i,
    input  logic                  flush_vaddr_is0_i,
    input  logic [ASID_WIDTH-1:0] flush_asid_i,
    input  logic [31:0]           flush_vaddr_i,
    input  logic                  upd_valid_i,
    input  logic                  upd_is_4M_i,
    input  logic [SV32_VPN_W-1:0] upd_vpn_i,
    input  logic [ASID_WIDTH-1:0] upd_asid_i,
    input  logic [29:0]           upd_pte_i,
    input  logic                  lu_access_i,
    input  logic [ASID_WIDTH-1:0] lu_asid_i,
    input  logic [31:0]           lu_vaddr_i,
    output logic                  lu_hit_o,
    output logic                  lu_is_4M_o,
    output logic [29:0]           lu_content_o
);
    localparam int IDX_W = $clog2(TLB_ENTRIES);

    logic [TLB_ENTRIES-1:0] valid_q, valid_d;
    logic [TLB_ENTRIES-1:0] is_4m_q;
    logic [VPN_LEVEL_W-1:0] vpn1_q [TLB_ENTRIES];
    logic [VPN_LEVEL_W-1:0] vpn0_q [TLB_ENTRIES];
    logic [ASID_WIDTH-1:0]  asid_q [TLB_ENTRIES];
    pte_sv32_t              pte_q  [TLB_ENTRIES];

    logic [TLB_ENTRIES-1:0] w_lu_match;
    logic [TLB_ENTRIES-1:0] w_fl_va_match;
    logic [TLB_ENTRIES-1:0] w_fl_asid_match;
    logic [TLB_ENTRIES-1:0] w_flush_clr;
    logic [IDX_W-1:0]       w_hit_idx;
    logic [IDX_W-1:0]       w_plru_victim;
    logic [IDX_W-1:0]       w_repl_idx;
    logic                   w_fill_en;
    logic                   w_unused;

    assign w_unused  = ^{lu_vaddr_i[11:0], flush_vaddr_i[11:0]};
    assign w_fill_en = upd_valid_i & ~flush_i;

    always_comb begin
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            w_lu_match[i] = valid_q[i]
                          && (vpn1_q[i] == lu_vaddr_i[31:22])
                          && (is_4m_q[i] || (vpn0_q[i] == lu_vaddr_i[21:12]))
                          && (pte_q[i].g || (asid_q[i] == lu_asid_i));
        end
    end

    // Descending scan so the lowest-index match drives the outputs.
    always_comb begin
        lu_hit_o     = |w_lu_match;
        lu_is_4M_o   = 1'b0;
        lu_content_o = '0;
        w_hit_idx    = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (w_lu_match[i]) begin
                lu_is_4M_o   = is_4m_q[i];
                lu_content_o = pte_q[i];
                w_hit_idx    = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            w_fl_va_match[i]   = (vpn1_q[i] == flush_vaddr_i[31:22])
                               && (is_4m_q[i] || (vpn0_q[i] == flush_vaddr_i[21:12]));
            w_fl_asid_match[i] = (asid_q[i] == flush_asid_i) && !pte_q[i].g;
        end
        case ({flush_asid_is0_i, flush_vaddr_is0_i})
            2'b11:   w_flush_clr = '1;
            2'b01:   w_flush_clr = w_fl_asid_match;
            2'b10:   w_flush_clr = w_fl_va_match;
            default: w_flush_clr = w_fl_va_match & w_fl_asid_match;
        endcase
    end

    always_comb begin
        w_repl_idx = w_plru_victim;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                w_repl_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = valid_q & ~w_flush_clr;
        end else if (upd_valid_i) begin
            valid_d[w_repl_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/PTE storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (w_fill_en) begin
            is_4m_q[w_repl_idx] <= upd_is_4M_i;
            vpn1_q[w_repl_idx]  <= upd_vpn_i[19:10];
            vpn0_q[w_repl_idx]  <= upd_vpn_i[9:0];
            asid_q[w_repl_idx]  <= upd_asid_i;
            pte_q[w_repl_idx]   <= upd_pte_i;
        end
    end

    sv32_itlb_plru_plru_tree #(
        .N (TLB_ENTRIES)
    ) u_plru (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .hit_valid_i  (lu_access_i & lu_hit_o),
        .hit_idx_i    (w_hit_idx),
        .fill_valid_i (w_fill_en),
        .fill_idx_i   (w_repl_idx),
        .victim_idx_o (w_plru_victim)
    );

endmodule
`default_nettype wire

// File: tb/tb_sv32_itlb_plru.sv
`default_nettype none
// ============================================================================
// tb_sv32_itlb_plru : directed + randomized bench with a behavioural TLB model
// Revision: 1.0
// ============================================================================
module tb_sv32_itlb_plru;
    localparam int N  = 2;
    localparam int AW = 9;
    localparam int L  = $clog2(N);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          flush_i, flush_asid_is0_i, flush_vaddr_is0_i;
    logic [AW-1:0] flush_asid_i;
    logic [31:0]   flush_vaddr_i;
    logic          upd_valid_i, upd_is_4M_i;
    logic [19:0]   upd_vpn_i;
    logic [AW-1:0] upd_asid_i;
    logic [29:0]   upd_pte_i;
    logic          lu_access_i;
    logic [AW-1:0] lu_asid_i;
    logic [31:0]   lu_vaddr_i;
    logic          lu_hit_o, lu_is_4M_o;
    logic [29:0]   lu_content_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    sv32_itlb_plru #(.TLB_ENTRIES(N), .ASID_WIDTH(AW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .flush_i(flush_i), .flush_asid_is0_i(flush_asid_is0_i),
        .flush_vaddr_is0_i(flush_vaddr_is0_i), .flush_asid_i(flush_asid_i),
        .flush_vaddr_i(flush_vaddr_i), .upd_valid_i(upd_valid_i),
        .upd_is_4M_i(upd_is_4M_i), .upd_vpn_i(upd_vpn_i), .upd_asid_i(upd_asid_i),
        .upd_pte_i(upd_pte_i), .lu_access_i(lu_access_i), .lu_asid_i(lu_asid_i),
        .lu_vaddr_i(lu_vaddr_i), .lu_hit_o(lu_hit_o), .lu_is_4M_o(lu_is_4M_o),
        .lu_content_o(lu_content_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- behavioural model ----------------
    bit          m_valid [N];
    bit          m_4m    [N];
    logic [9:0]  m_vpn1  [N];
    logic [9:0]  m_vpn0  [N];
    logic [8:0]  m_asid  [N];
    logic [29:0] m_pte   [N];
    // m_dir[level][prefix]: which half (0 left, 1 right) the next victim lies in
    int          m_dir   [0:3][0:15];

    function automatic void m_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 0;
        for (int d = 0; d < 4; d++)
            for (int p = 0; p < 16; p++) m_dir[d][p] = 0;
    endfunction

    function automatic void m_touch(input int idx);
        for (int d = 0; d < L; d++)
            m_dir[d][idx >> (L - d)] = ((idx >> (L - 1 - d)) & 1) ? 0 : 1;
    endfunction

    function automatic int m_victim();
        int v = 0;
        for (int d = 0; d < L; d++) v = v * 2 + m_dir[d][v];
        return v;
    endfunction

    function automatic void m_lookup(input logic [31:0] va, input logic [8:0] asid,
                                     output logic hit, output logic is4m,
                                     output logic [29:0] pte, output int idx);
        hit = 0; is4m = 0; pte = '0; idx = 0;
        for (int i = 0; i < N; i++) begin
            if (!hit && m_valid[i] && m_vpn1[i] == va[31:22]
                && (m_4m[i] || m_vpn0[i] == va[21:12])
                && (m_pte[i][5] || m_asid[i] == asid)) begin
                hit = 1; is4m = m_4m[i]; pte = m_pte[i]; idx = i;
            end
        end
    endfunction

    always @(negedge rst_ni) m_clear();

    always @(posedge clk_i) begin
        logic h, f4;
        logic [29:0] pc;
        int hidx, v;
        bit va_m, as_m, clr;
        if (rst_ni) begin
            m_lookup(lu_vaddr_i, lu_asid_i, h, f4, pc, hidx);
            v = -1;
            if (flush_i) begin
                for (int i = 0; i < N; i++) begin
                    va_m = (m_vpn1[i] == flush_vaddr_i[31:22])
                           && (m_4m[i] || m_vpn0[i] == flush_vaddr_i[21:12]);
                    as_m = (m_asid[i] == flush_asid_i) && !m_pte[i][5];
                    if (flush_asid_is0_i && flush_vaddr_is0_i) clr = 1;
                    else if (flush_vaddr_is0_i)                clr = as_m;
                    else if (flush_asid_is0_i)                 clr = va_m;
                    else                                       clr = va_m && as_m;
                    if (clr) m_valid[i] = 0;
                end
            end else if (upd_valid_i) begin
                for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) v = i;
                if (v < 0) v = m_victim();
                m_valid[v] = 1; m_4m[v] = upd_is_4M_i;
                m_vpn1[v] = upd_vpn_i[19:10]; m_vpn0[v] = upd_vpn_i[9:0];
                m_asid[v] = upd_asid_i; m_pte[v] = upd_pte_i;
            end
            if (v >= 0) m_touch(v);
            else if (lu_access_i && h) m_touch(hidx);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk_i) begin
        logic eh, e4;
        logic [29:0] ec;
        int ei;
        if (chk_en) begin
            m_lookup(lu_vaddr_i, lu_asid_i, eh, e4, ec, ei);
            check("model_hit", lu_hit_o, eh);
            check("model_is4M", lu_is_4M_o, e4);
            check("model_content", lu_content_o, ec);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [29:0] mkpte(input logic [21:0] ppn, input logic g);
        return {ppn, 2'b00, g, 1'b0, 4'b1011};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        flush_i = 0; flush_asid_is0_i = 0; flush_vaddr_is0_i = 0;
        flush_asid_i = '0; flush_vaddr_i = '0;
        upd_valid_i = 0; upd_is_4M_i = 0; upd_vpn_i = '0; upd_asid_i = '0; upd_pte_i = '0;
        lu_access_i = 0;
    endtask

    task automatic fill(input logic is4m, input logic [19:0] vpn, input logic [8:0] asid,
                        input logic [29:0] pte);
        upd_valid_i = 1; upd_is_4M_i = is4m; upd_vpn_i = vpn; upd_asid_i = asid; upd_pte_i = pte;
        tick();
        upd_valid_i = 0;
    endtask

    task automatic flush(input logic a0, input logic v0, input logic [8:0] asid,
                         input logic [31:0] va);
        flush_i = 1; flush_asid_is0_i = a0; flush_vaddr_is0_i = v0;
        flush_asid_i = asid; flush_vaddr_i = va;
        tick();
        flush_i = 0;
    endtask

    task automatic look(input logic [31:0] va, input logic [8:0] asid, input logic acc);
        lu_vaddr_i = va; lu_asid_i = asid; lu_access_i = acc;
        #1;
    endtask

    task automatic expect_lu(input string name, input logic hit, input logic is4m,
                             input logic [29:0] content);
        check({name, "_hit"}, lu_hit_o, hit);
        check({name, "_is4M"}, lu_is_4M_o, is4m);
        check({name, "_content"}, lu_content_o, content);
    endtask

    initial begin
        logic [29:0] pa, pb, pc, pg;
        idle();
        lu_vaddr_i = 32'h8000_1000; lu_asid_i = '0;
        #1 rst_ni = 0;
        #1 chk_en = 1;
        expect_lu("reset", 0, 0, '0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1;
        tick();
        look(32'h8000_1000, 9'd0, 0);
        expect_lu("empty", 0, 0, '0);

        // basic 4K fill and ASID discrimination
        pa = mkpte(22'h12345, 0);
        fill(0, 20'h80001, 9'd3, pa);
        look(32'h8000_1ABC, 9'd3, 0);
        expect_lu("fill4k", 1, 0, pa);
        check("fill4k_ppn", {10'h0, lu_content_o[29:8]}, 32'h0001_2345);
        look(32'h8000_1ABC, 9'd4, 0);
        expect_lu("asid_miss", 0, 0, '0);

        // global superpage: any ASID, any VPN0
        pg = mkpte(22'h00400, 1);
        fill(1, {10'h200, 10'h000}, 9'd7, pg);
        look(32'h8034_5000, 9'h1FF, 0);
        expect_lu("super", 1, 1, pg);

        // PLRU: A, B, hit A, C -> C replaces B
        flush(1, 1, 9'd0, 32'h0);
        pa = mkpte(22'h0000A, 0); pb = mkpte(22'h0000B, 0); pc = mkpte(22'h0000C, 0);
        fill(0, 20'h11111, 9'd1, pa);
        fill(0, 20'h22222, 9'd1, pb);
        look(32'h1111_1000, 9'd1, 1);
        tick();
        lu_access_i = 0;
        fill(0, 20'h33333, 9'd1, pc);
        look(32'h1111_1000, 9'd1, 0); expect_lu("plru_A", 1, 0, pa);
        look(32'h3333_3000, 9'd1, 0); expect_lu("plru_C", 1, 0, pc);
        look(32'h2222_2000, 9'd1, 0); check("plru_B_gone", lu_hit_o, 0);

        // ASID flush keeps other ASIDs and global entries
        flush(1, 1, 9'd0, 32'h0);
        fill(0, 20'h40001, 9'd3, mkpte(22'h1, 0));
        fill(0, 20'h40002, 9'd5, mkpte(22'h2, 0));
        flush(0, 1, 9'd3, 32'h0);
        look(32'h4000_1000, 9'd3, 0); check("asidfl_3", lu_hit_o, 0);
        look(32'h4000_2000, 9'd5, 0); check("asidfl_5", lu_hit_o, 1);
        fill(0, 20'h40003, 9'd3, mkpte(22'h3, 1));
        flush(0, 1, 9'd3, 32'h0);
        look(32'h4000_3000, 9'd3, 0); check("asidfl_glob", lu_hit_o, 1);
        look(32'h4000_2000, 9'd5, 0); check("asidfl_5b", lu_hit_o, 1);
        flush(1, 1, 9'd0, 32'h0);
        look(32'h4000_3000, 9'd3, 0); check("full_glob", lu_hit_o, 0);
        look(32'h4000_2000, 9'd5, 0); check("full_5", lu_hit_o, 0);

        // flush and fill together: fill dropped
        upd_valid_i = 1; upd_is_4M_i = 1; upd_vpn_i = 20'h50000; upd_asid_i = 9'd1;
        upd_pte_i = mkpte(22'h5, 1);
        flush(1, 1, 9'd0, 32'h0);
        upd_valid_i = 0;
        look(32'h5000_0000, 9'd1, 0); check("flush_beats_fill", lu_hit_o, 0);

        // async reset drops the hit immediately
        fill(0, 20'h60006, 9'd2, mkpte(22'h6, 0));
        look(32'h6000_6000, 9'd2, 1); check("pre_rst_hit", lu_hit_o, 1);
        rst_ni = 0;
        #1 check("async_rst_hit", lu_hit_o, 0);
        tick();
        rst_ni = 1;
        lu_access_i = 0;
        tick();

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            flush_i           = ($urandom_range(0, 11) == 0);
            flush_asid_is0_i  = $urandom_range(0, 1);
            flush_vaddr_is0_i = $urandom_range(0, 1);
            flush_asid_i      = 9'($urandom_range(0, 3));
            flush_vaddr_i     = {10'h200 + 10'($urandom_range(0, 1)), 10'($urandom_range(0, 2)), 12'h0};
            upd_valid_i       = ($urandom_range(0, 3) == 0);
            upd_is_4M_i       = ($urandom_range(0, 3) == 0);
            upd_vpn_i         = {10'h200 + 10'($urandom_range(0, 1)), 10'($urandom_range(0, 2))};
            upd_asid_i        = 9'($urandom_range(0, 3));
            upd_pte_i         = mkpte(22'($urandom), ($urandom_range(0, 3) == 0));
            lu_access_i       = $urandom_range(0, 1);
            lu_asid_i         = 9'($urandom_range(0, 3));
            lu_vaddr_i        = {10'h200 + 10'($urandom_range(0, 1)), 10'($urandom_range(0, 2)), 12'($urandom)};
            tick();
        end
        idle();
        tick();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
